// File: rtl/rx_fifo_ctl.sv
// Purpose : UART receive buffer; captures rx-core bytes into a circular buffer and flags overrun / idle timeout.
// Latency : byte pushed in cycle N appears on rd_data with rd_valid=1 in cycle N+1 (first-word fall-through).
// Backpr. : rd_valid/rd_ready read port; bytes arriving while full with no pop are dropped and overrun is set.
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   bclk            baud tick pulse (same one the rx core uses)
//   rx_dout         byte from rx core, qualified by rx_dout_rdy pulse
//   rx_rdy          rx core idle, no frame in progress
//   rd_data         head byte; rd_valid = buffer non-empty; rd_ready pops
//   count, full     occupancy 0..DEPTH and count==DEPTH
//   overrun/ovr_clr sticky drop flag and its clear
//   timeout         buffered bytes left unread while line idle for TIMEOUT_TICKS ticks
module rx_fifo_ctl #(
    parameter int DEPTH         = 16,
    parameter int ADDR_W        = 4,
    parameter int TIMEOUT_TICKS = 40
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bclk,
    input  logic [7:0]        rx_dout,
    input  logic              rx_dout_rdy,
    input  logic              rx_rdy,
    output logic [7:0]        rd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              overrun,
    input  logic              ovr_clr,
    output logic              timeout
);

    localparam int TW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [ADDR_W:0] FULL_CNT  = (ADDR_W + 1)'(DEPTH);
    localparam logic [TW-1:0]   TLAST     = TW'(TIMEOUT_TICKS - 1);

    typedef enum logic [1:0] {
        S_EMPTY   = 2'd0,
        S_ARMED   = 2'd1,
        S_EXPIRED = 2'd2
    } state_t;

    logic [7:0]        mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              overrun_q, overrun_d;
    state_t            state_q, state_d;
    logic [TW-1:0]     tcnt_q, tcnt_d;

    logic push, pop, drop, tick;

    // All status outputs come from registered state only.
    assign rd_valid = (count_q != '0);
    assign full     = (count_q == FULL_CNT);
    assign count    = count_q;
    assign overrun  = overrun_q;
    assign timeout  = (state_q == S_EXPIRED);
    assign rd_data  = mem_q[rd_ptr_q];

    assign pop  = rd_valid & rd_ready;
    // A pop in the same cycle frees the slot, so a full buffer can still accept.
    assign push = rx_dout_rdy & (~full | pop);
    assign drop = rx_dout_rdy & full & ~pop;
    // Baud ticks only count while the line is quiet.
    assign tick = bclk & rx_rdy;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        if (push) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);

        if (push && !pop)      count_d = count_q + (ADDR_W + 1)'(1);
        else if (pop && !push) count_d = count_q - (ADDR_W + 1)'(1);

        // A drop in the same cycle as a clear wins, so no drop goes unreported.
        if (drop)         overrun_d = 1'b1;
        else if (ovr_clr) overrun_d = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        tcnt_d  = tcnt_q;

        case (state_q)
            S_EMPTY: begin
                tcnt_d = '0;
                if (push) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (count_d == '0) begin
                    state_d = S_EMPTY;
                    tcnt_d  = '0;
                end else if (push || pop) begin
                    tcnt_d = '0;
                end else if (tick) begin
                    // Counter stops at the expiry value instead of wrapping.
                    if (tcnt_q == TLAST) state_d = S_EXPIRED;
                    else                 tcnt_d  = tcnt_q + TW'(1);
                end
            end
            S_EXPIRED: begin
                if (count_d == '0) begin
                    state_d = S_EMPTY;
                    tcnt_d  = '0;
                end else if (push || pop) begin
                    state_d = S_ARMED;
                    tcnt_d  = '0;
                end
            end
            default: begin
                state_d = S_EMPTY;
                tcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
            state_q   <= S_EMPTY;
            tcnt_q    <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
            state_q   <= state_d;
            tcnt_q    <= tcnt_d;
        end
    end

    // Storage needs no reset; contents are only visible while rd_valid is high.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= rx_dout;
    end

endmodule

// File: tb/tb_rx_fifo_ctl.sv
// Purpose : directed self-checking bench for rx_fifo_ctl.
// Latency : inputs driven 1 time unit after posedge, outputs checked at the same point.
// Backpr. : consumer rd_ready driven directly by the stimulus sequence.
module tb_rx_fifo_ctl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bclk = 1'b0;
    logic [7:0] rx_dout = 8'h00;
    logic       rx_dout_rdy = 1'b0;
    logic       rx_rdy = 1'b1;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic [4:0] count;
    logic       full;
    logic       overrun;
    logic       ovr_clr = 1'b0;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rx_fifo_ctl #(.DEPTH(16), .ADDR_W(4), .TIMEOUT_TICKS(40)) dut (
        .clk        (clk),
        .rst        (rst),
        .bclk       (bclk),
        .rx_dout    (rx_dout),
        .rx_dout_rdy(rx_dout_rdy),
        .rx_rdy     (rx_rdy),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .count      (count),
        .full       (full),
        .overrun    (overrun),
        .ovr_clr    (ovr_clr),
        .timeout    (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_dout     = b;
        rx_dout_rdy = 1'b1;
        step();
        rx_dout_rdy = 1'b0;
    endtask

    task automatic pop();
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
    endtask

    // One baud tick followed by one quiet cycle.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bclk = 1'b1;
            step();
            bclk = 1'b0;
            step();
        end
    endtask

    initial begin
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_count", count, 0);
        chk("rst_valid", rd_valid, 0);
        chk("rst_full", full, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_timeout", timeout, 0);

        // 1. single byte, one cycle latency
        push(8'hA5);
        chk("t1_valid", rd_valid, 1);
        chk("t1_data", rd_data, 8'hA5);
        chk("t1_count", count, 1);
        pop();
        chk("t1_count0", count, 0);
        chk("t1_valid0", rd_valid, 0);

        // push while empty with rd_ready high: no pop occurs
        rd_ready = 1'b1;
        push(8'h3C);
        rd_ready = 1'b0;
        chk("empty_push_rdy_count", count, 1);
        chk("empty_push_rdy_data", rd_data, 8'h3C);
        pop();
        chk("empty_push_rdy_drain", count, 0);

        // 2. fill, overrun, ordered drain, clear
        for (int i = 0; i < 16; i++) push(8'(i));
        chk("t2_full", full, 1);
        chk("t2_count16", count, 16);
        chk("t2_ovr0", overrun, 0);
        push(8'h55);
        chk("t2_ovr1", overrun, 1);
        chk("t2_count_after_drop", count, 16);
        for (int i = 0; i < 16; i++) begin
            chk("t2_order", rd_data, 32'(i));
            pop();
        end
        chk("t2_empty", count, 0);
        chk("t2_ovr_sticky", overrun, 1);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("t2_ovr_clr", overrun, 0);

        // 3. full with simultaneous push and pop
        for (int i = 0; i < 16; i++) push(8'(8'h10 + i));
        rx_dout     = 8'h77;
        rx_dout_rdy = 1'b1;
        rd_ready    = 1'b1;
        step();
        rx_dout_rdy = 1'b0;
        rd_ready    = 1'b0;
        chk("t3_count16", count, 16);
        chk("t3_ovr0", overrun, 0);
        chk("t3_head", rd_data, 8'h11);
        // drop and clear in the same cycle: set wins
        rx_dout     = 8'h99;
        rx_dout_rdy = 1'b1;
        ovr_clr     = 1'b1;
        step();
        rx_dout_rdy = 1'b0;
        ovr_clr     = 1'b0;
        chk("t3_set_beats_clr", overrun, 1);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("t3_clr", overrun, 0);
        for (int i = 1; i < 16; i++) begin
            chk("t3_order", rd_data, 32'(8'h10 + i));
            pop();
        end
        chk("t3_last", rd_data, 8'h77);
        pop();
        chk("t3_empty", count, 0);

        // 4. idle timeout
        rx_rdy = 1'b1;
        push(8'h01);
        ticks(39);
        chk("t4_39_no_to", timeout, 0);
        push(8'h02);
        chk("t4_push_no_to", timeout, 0);
        ticks(39);
        chk("t4_restart_39", timeout, 0);
        ticks(1);
        chk("t4_to_40", timeout, 1);

        // 5. timeout cleared by pops, ticks with line busy ignored
        pop();
        chk("t5_pop_clears", timeout, 0);
        chk("t5_count1", count, 1);
        ticks(40);
        chk("t5_reexpire", timeout, 1);
        pop();
        chk("t5_empty_to", timeout, 0);
        chk("t5_empty_cnt", count, 0);
        ticks(50);
        chk("t5_empty_ticks", timeout, 0);
        push(8'h03);
        rx_rdy = 1'b0;
        ticks(60);
        chk("t5_busy_ticks", timeout, 0);
        rx_rdy = 1'b1;
        ticks(39);
        chk("t5_idle_39", timeout, 0);
        ticks(1);
        chk("t5_idle_40", timeout, 1);
        pop();
        chk("t5_final_empty", count, 0);

        // 6. reset mid-stream, then wrap round trips
        for (int i = 0; i < 9; i++) push(8'(8'hC0 + i));
        ticks(40);
        chk("t6_pre_to", timeout, 1);
        chk("t6_pre_count", count, 9);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_rst_count", count, 0);
        chk("t6_rst_valid", rd_valid, 0);
        chk("t6_rst_ovr", overrun, 0);
        chk("t6_rst_to", timeout, 0);
        for (int k = 0; k < 48; k++) begin
            push(8'((k * 7 + 3) & 8'hFF));
            chk("t6_wrap_data", rd_data, 32'((k * 7 + 3) & 8'hFF));
            pop();
            chk("t6_wrap_cnt", count, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
